// File: rtl/coord_pkg.sv
// rtl/coord_pkg.sv - shared widths, frame extents, pixel layout and stage records for coord_shader
package coord_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int XS_W    = X_W + 1;
    localparam int YS_W    = Y_W + 1;
    localparam int RSQ_W   = 21;
    localparam int PIX_W   = 24;
    localparam int CNT_W   = 8;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;

    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 0;

    // Stage 1: offset coordinates plus the frame count sampled at accept.
    typedef struct packed {
        logic signed [XS_W-1:0] xs;
        logic signed [YS_W-1:0] ys;
        logic [CNT_W-1:0]       fc;
        logic                   first;
        logic                   lastx;
    } s1_t;

    // Stage 2: radius squared.
    typedef struct packed {
        logic [RSQ_W-1:0] rsq;
        logic [CNT_W-1:0] fc;
        logic             first;
        logic             lastx;
    } s2_t;

    // Stage 3: final RGB pixel as presented downstream.
    typedef struct packed {
        logic [PIX_W-1:0] pixel;
        logic             first;
        logic             lastx;
    } s3_t;

    // R carries the hue, G its complement, B the hue tinted by the frame count.
    function automatic logic [PIX_W-1:0] make_pixel(input logic [7:0] hue, input logic [7:0] fc);
        logic [PIX_W-1:0] p;
        p                    = '0;
        p[PIX_R_LSB +: 8]    = hue;
        p[PIX_G_LSB +: 8]    = ~hue;
        p[PIX_B_LSB +: 8]    = hue ^ fc;
        return p;
    endfunction

endpackage

// File: rtl/coord_shader_if.sv
// rtl/coord_shader_if.sv - coordinate-in / pixel-out stream bundle for coord_shader
interface coord_shader_if;
    import coord_pkg::*;

    logic [X_W-1:0]   in_x;
    logic [Y_W-1:0]   in_y;
    logic             in_first;
    logic             in_lastx;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_first;
    logic             out_lastx;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_x, in_y, in_first, in_lastx, in_valid, out_ready,
        output in_ready, out_pixel, out_first, out_lastx, out_valid
    );

    modport master (
        output in_x, in_y, in_first, in_lastx, in_valid, out_ready,
        input  in_ready, out_pixel, out_first, out_lastx, out_valid
    );

endinterface

// File: rtl/coord_shader_pipe_reg.sv
// rtl/coord_shader_pipe_reg.sv - enabled valid+data pipeline register with async active-low clear
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d,  data_q;

    // Hold everything on stall; data only loads with a real beat so bubbles leave it untouched.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/coord_shader.sv
// rtl/coord_shader.sv - 3-stage stallable radial colour shader for the 640x480 render path
module coord_shader #(
    parameter int X_OFF   = 0,
    parameter int Y_OFF   = 0,
    parameter int R_SHIFT = 0
) (
    input  logic           clk,
    input  logic           resetn,
    coord_shader_if.slave  io
);
    import coord_pkg::*;

    localparam logic signed [XS_W-1:0] X_OFF_C = XS_W'(X_OFF);
    localparam logic signed [YS_W-1:0] Y_OFF_C = YS_W'(Y_OFF);

    logic             adv;
    logic             accept;
    logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;
    logic s1_vld, s2_vld, s3_vld;

    logic signed [2*XS_W-1:0] xsq;
    logic signed [2*YS_W-1:0] ysq;
    logic [7:0]               hue;

    // Whole pipe moves as one: it advances whenever the output slot is free or draining.
    always_comb begin
        adv    = !s3_vld || io.out_ready;
        accept = io.in_valid && adv;
    end

    // A first-of-frame beat bumps the counter; that beat itself already sampled the old value.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (accept && io.in_first) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Per-stage datapath: offset, square-and-sum, then hue and RGB mapping.
    always_comb begin
        s1_d.xs    = $signed({io.in_x[X_W-1], io.in_x}) + X_OFF_C;
        s1_d.ys    = $signed({io.in_y[Y_W-1], io.in_y}) + Y_OFF_C;
        s1_d.fc    = frame_cnt_q;
        s1_d.first = io.in_first;
        s1_d.lastx = io.in_lastx;

        xsq        = s1_q.xs * s1_q.xs;
        ysq        = s1_q.ys * s1_q.ys;
        s2_d.rsq   = RSQ_W'($unsigned(xsq)) + RSQ_W'($unsigned(ysq));
        s2_d.fc    = s1_q.fc;
        s2_d.first = s1_q.first;
        s2_d.lastx = s1_q.lastx;

        hue        = 8'(s2_q.rsq >> R_SHIFT) + s2_q.fc;
        s3_d.pixel = make_pixel(hue, s2_q.fc);
        s3_d.first = s2_q.first;
        s3_d.lastx = s2_q.lastx;
    end

    pipe_reg #(.W($bits(s1_t))) u_s1 (
        .clk       (clk),
        .resetn    (resetn),
        .en        (adv),
        .in_valid  (io.in_valid),
        .in_data   (s1_d),
        .out_valid (s1_vld),
        .out_data  (s1_q)
    );

    pipe_reg #(.W($bits(s2_t))) u_s2 (
        .clk       (clk),
        .resetn    (resetn),
        .en        (adv),
        .in_valid  (s1_vld),
        .in_data   (s2_d),
        .out_valid (s2_vld),
        .out_data  (s2_q)
    );

    pipe_reg #(.W($bits(s3_t))) u_s3 (
        .clk       (clk),
        .resetn    (resetn),
        .en        (adv),
        .in_valid  (s2_vld),
        .in_data   (s3_d),
        .out_valid (s3_vld),
        .out_data  (s3_q)
    );

    assign io.in_ready  = adv;
    assign io.out_valid = s3_vld;
    assign io.out_pixel = s3_q.pixel;
    assign io.out_first = s3_q.first;
    assign io.out_lastx = s3_q.lastx;

endmodule

// File: tb/tb_coord_shader.sv
// tb/tb_coord_shader.sv - directed self-checking bench for coord_shader
module tb_coord_shader;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    coord_shader_if if0 ();
    coord_shader_if if4 ();

    coord_shader #(.X_OFF(0), .Y_OFF(0), .R_SHIFT(0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (if0.slave)
    );

    coord_shader #(.X_OFF(0), .Y_OFF(0), .R_SHIFT(4)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .io     (if4.slave)
    );

    assign if4.in_x      = if0.in_x;
    assign if4.in_y      = if0.in_y;
    assign if4.in_first  = if0.in_first;
    assign if4.in_lastx  = if0.in_lastx;
    assign if4.in_valid  = if0.in_valid;
    assign if4.out_ready = if0.out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] pix_q[$];
    logic        first_q[$];
    logic        lastx_q[$];

    always @(negedge clk) begin
        if (resetn && if0.out_valid && if0.out_ready) begin
            pix_q.push_back(if0.out_pixel);
            first_q.push_back(if0.out_first);
            lastx_q.push_back(if0.out_lastx);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        if0.in_valid = 1'b0;
        if0.in_first = 1'b0;
        if0.in_lastx = 1'b0;
        if0.in_x     = '0;
        if0.in_y     = '0;
    endtask

    task automatic put(input int x, input int y, input logic f, input logic l);
        if0.in_x     = 10'(x);
        if0.in_y     = 9'(y);
        if0.in_first = f;
        if0.in_lastx = l;
        if0.in_valid = 1'b1;
    endtask

    task automatic clear_q();
        pix_q.delete();
        first_q.delete();
        lastx_q.delete();
    endtask

    task automatic apply_reset();
        resetn        = 1'b0;
        idle();
        if0.out_ready = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        clear_q();
        tick();
    endtask

    task automatic wait_outputs(input int n, input int budget);
        for (int i = 0; i < budget && pix_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        idle();
        if0.out_ready = 1'b0;
        #3;
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", if0.out_valid); end
        n_vec++; if (if0.out_pixel !== 24'h0) begin n_err++; $display("FAIL rst_out_pixel got %h want 000000", if0.out_pixel); end
        n_vec++; if (if0.out_first !== 1'b0) begin n_err++; $display("FAIL rst_out_first got %b want 0", if0.out_first); end
        n_vec++; if (if0.out_lastx !== 1'b0) begin n_err++; $display("FAIL rst_out_lastx got %b want 0", if0.out_lastx); end
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", if0.in_ready); end
        repeat (2) tick();
        resetn        = 1'b1;
        if0.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", if0.in_ready); end
        tick();
    endtask

    task automatic test_single_beat();
        put(3, 4, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_c1 out_valid got %b want 0", if0.out_valid); end
        tick();
        @(negedge clk);
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_c2 out_valid got %b want 0", if0.out_valid); end
        tick();
        @(negedge clk);
        n_vec++; if (if0.out_valid !== 1'b1) begin n_err++; $display("FAIL lat_c3 out_valid got %b want 1", if0.out_valid); end
        n_vec++; if (if0.out_pixel !== 24'h19E619) begin n_err++; $display("FAIL single_pixel got %h want 19e619", if0.out_pixel); end
        n_vec++; if (if0.out_first !== 1'b0) begin n_err++; $display("FAIL single_first got %b want 0", if0.out_first); end
        n_vec++; if (if0.out_lastx !== 1'b0) begin n_err++; $display("FAIL single_lastx got %b want 0", if0.out_lastx); end
        tick();
        @(negedge clk);
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL single_after out_valid got %b want 0", if0.out_valid); end
        tick();
    endtask

    task automatic test_corner();
        put(-320, 240, 1'b0, 1'b1);
        tick();
        idle();
        repeat (2) tick();
        @(negedge clk);
        n_vec++; if (if0.out_valid !== 1'b1) begin n_err++; $display("FAIL corner_valid got %b want 1", if0.out_valid); end
        n_vec++; if (if0.out_pixel !== 24'h00FF00) begin n_err++; $display("FAIL corner_pix_sh0 got %h want 00ff00", if0.out_pixel); end
        n_vec++; if (if0.out_lastx !== 1'b1) begin n_err++; $display("FAIL corner_lastx got %b want 1", if0.out_lastx); end
        n_vec++; if (if4.out_pixel !== 24'h10EF10) begin n_err++; $display("FAIL corner_pix_sh4 got %h want 10ef10", if4.out_pixel); end
        n_vec++; if (if4.out_lastx !== 1'b1) begin n_err++; $display("FAIL corner_lastx_sh4 got %b want 1", if4.out_lastx); end
        tick();
    endtask

    task automatic test_frame_count();
        put(3, 4, 1'b1, 1'b0);
        tick();
        put(3, 4, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        @(negedge clk);
        n_vec++; if (if0.out_pixel !== 24'h19E619) begin n_err++; $display("FAIL fc_beat0_pix got %h want 19e619", if0.out_pixel); end
        n_vec++; if (if0.out_first !== 1'b1) begin n_err++; $display("FAIL fc_beat0_first got %b want 1", if0.out_first); end
        tick();
        @(negedge clk);
        n_vec++; if (if0.out_valid !== 1'b1) begin n_err++; $display("FAIL fc_beat1_valid got %b want 1", if0.out_valid); end
        n_vec++; if (if0.out_pixel !== 24'h1AE51B) begin n_err++; $display("FAIL fc_beat1_pix got %h want 1ae51b", if0.out_pixel); end
        n_vec++; if (if0.out_first !== 1'b0) begin n_err++; $display("FAIL fc_beat1_first got %b want 0", if0.out_first); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_pix [10];
        logic [23:0] held;
        logic        want_rdy;
        int          idx;
        exp_pix = '{24'h00FF00, 24'h01FE01, 24'h04FB04, 24'h09F609, 24'h10EF10,
                    24'h1AE51B, 24'h25DA24, 24'h32CD33, 24'h41BE40, 24'h52AD53};
        apply_reset();
        idx  = 0;
        held = '0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            if0.out_ready = !(c >= 4 && c <= 8);
            put(idx, 0, idx == 4, idx == 9);
            @(negedge clk);
            want_rdy = !(c >= 4 && c <= 8);
            if (c <= 9) begin
                n_vec++; if (if0.in_ready !== want_rdy) begin n_err++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, if0.in_ready, want_rdy); end
            end
            if (c == 4) begin
                held = if0.out_pixel;
                n_vec++; if (held !== 24'h01FE01) begin n_err++; $display("FAIL bp_held_pix got %h want 01fe01", held); end
            end
            if (c >= 5 && c <= 8) begin
                n_vec++; if (if0.out_pixel !== held || if0.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_stable c=%0d got %h/%b want %h/1", c, if0.out_pixel, if0.out_valid, held); end
            end
            if (if0.in_ready) idx++;
            tick();
        end
        idle();
        if0.out_ready = 1'b1;
        wait_outputs(10, 50);
        n_vec++; if (pix_q.size() !== 10) begin n_err++; $display("FAIL bp_count got %0d want 10", pix_q.size()); end
        for (int i = 0; i < 10 && i < pix_q.size(); i++) begin
            n_vec++; if (pix_q[i] !== exp_pix[i]) begin n_err++; $display("FAIL bp_pix[%0d] got %h want %h", i, pix_q[i], exp_pix[i]); end
            n_vec++; if (first_q[i] !== (i == 4)) begin n_err++; $display("FAIL bp_first[%0d] got %b want %b", i, first_q[i], (i == 4)); end
            n_vec++; if (lastx_q[i] !== (i == 9)) begin n_err++; $display("FAIL bp_lastx[%0d] got %b want %b", i, lastx_q[i], (i == 9)); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 256; k++) begin
            put(3, 4, 1'b1, 1'b0);
            tick();
        end
        put(3, 4, 1'b0, 1'b0);
        tick();
        idle();
        wait_outputs(257, 50);
        n_vec++; if (pix_q.size() !== 257) begin n_err++; $display("FAIL wrap_count got %0d want 257", pix_q.size()); end
        if (pix_q.size() >= 257) begin
            n_vec++; if (pix_q[0] !== 24'h19E619) begin n_err++; $display("FAIL wrap_pix0 got %h want 19e619", pix_q[0]); end
            n_vec++; if (pix_q[1] !== 24'h1AE51B) begin n_err++; $display("FAIL wrap_pix1 got %h want 1ae51b", pix_q[1]); end
            n_vec++; if (pix_q[255] !== 24'h18E7E7) begin n_err++; $display("FAIL wrap_pix255 got %h want 18e7e7", pix_q[255]); end
            n_vec++; if (pix_q[256] !== 24'h19E619) begin n_err++; $display("FAIL wrap_pix256 got %h want 19e619", pix_q[256]); end
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        put(3, 4, 1'b0, 1'b0);
        tick();
        put(1, 1, 1'b0, 1'b0);
        tick();
        put(2, 2, 1'b0, 1'b0);
        tick();
        idle();
        n_vec++; if (if0.out_valid !== 1'b1) begin n_err++; $display("FAIL mid_prefill_valid got %b want 1", if0.out_valid); end
        #1;
        resetn = 1'b0;
        #1;
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", if0.out_valid); end
        n_vec++; if (if0.out_pixel !== 24'h0) begin n_err++; $display("FAIL mid_async_pixel got %h want 000000", if0.out_pixel); end
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %b want 1", if0.in_ready); end
        repeat (2) tick();
        resetn = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        n_vec++; if (pix_q.size() !== 0) begin n_err++; $display("FAIL mid_stale_count got %0d want 0", pix_q.size()); end
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_valid got %b want 0", if0.out_valid); end
        tick();
        put(5, 12, 1'b0, 1'b0);
        tick();
        idle();
        wait_outputs(1, 10);
        n_vec++; if (pix_q.size() !== 1) begin n_err++; $display("FAIL mid_post_count got %0d want 1", pix_q.size()); end
        if (pix_q.size() >= 1) begin
            n_vec++; if (pix_q[0] !== 24'hA956A9) begin n_err++; $display("FAIL mid_post_pix got %h want a956a9", pix_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_corner();
        test_frame_count();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/coord_shader.md
Name: coord_shader

Overview:
- Sits directly downstream of the coordinate generator in the 640x480 render path.
- Consumes one signed (x, y) beat per handshake and computes a radial colour: offset, square, sum, then map to 24-bit RGB through a 3-stage stallable pipeline.
- Carries the first/lastx sidebands alongside the data and presents a valid/ready pixel stream to the video output stage.

Parameters:
- X_OFF, 0, signed 10-bit horizontal centre offset added to x; legal range -256..255.
- Y_OFF, 0, signed 9-bit vertical centre offset added to y; legal range -128..127.
- R_SHIFT, 0, right shift applied to the radius-squared before colour mapping; legal range 0..12.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- in_x  in  10  signed pixel x
- in_y  in  9  signed pixel y
- in_first  in  1  first-pixel-of-frame flag
- in_lastx  in  1  last-pixel-of-line flag
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- out_pixel  out  24  RGB, {R[23:16], G[15:8], B[7:0]}
- out_first  out  1  in_first of this beat, delayed
- out_lastx  out  1  in_lastx of this beat, delayed
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts

Behaviour:
- Reset: async assert on resetn low. All stage valids, data and sideband registers, and frame_cnt (8-bit) clear to 0. Outputs are therefore out_valid=0, out_pixel=0, out_first=0, out_lastx=0. in_ready=1 during and after reset.
- Handshake:
  - Global enable adv = !out_valid || out_ready; in_ready = adv (combinational).
  - Input beat accepted when in_valid && in_ready. Output beat transferred when out_valid && out_ready.
  - All stages shift together on adv; no bubble collapsing.
  - out_* hold stable while out_valid && !out_ready.
- Latency: 3 cycles from acceptance to out_valid, with no stalls. Throughput 1 beat/cycle.
- Stage 1, captured on accept:
  - xs = in_x + X_OFF (11-bit signed); ys = in_y + Y_OFF (10-bit signed).
  - fc = frame_cnt; also latch in_first and in_lastx.
  - If adv && !in_valid, stage 1 valid loads 0.
- Stage 2: rsq = xs*xs + ys*ys, unsigned, 21 bits. No overflow is possible within the legal parameter ranges.
- Stage 3:
  - hue = (rsq >> R_SHIFT)[7:0] + fc, mod 256.
  - out_pixel = {hue, ~hue, hue ^ fc}.
- Frame counter:
  - frame_cnt increments (mod 256, wraps 255->0) when an accepted input beat has in_first=1.
  - The accepting beat itself uses the pre-increment value; beats accepted later use the new value.
- Stall: while !adv, no stage register changes and frame_cnt is unchanged, even if in_valid or in_first is high.
- in_valid && in_first while in_ready=0: not accepted, no counter increment.
- Reset mid-operation: in-flight beats are discarded. No partial beat appears after reset release; the first post-reset output is the 3rd cycle after the first accepted beat.
- in_valid is permitted to drop between beats. Bubbles propagate as out_valid=0 cycles.

Decomposition:
- Shared package coord_pkg:
  - X_W=10, Y_W=9, RSQ_W=21, PIX_W=24.
  - Frame extents 640/480.
  - Pixel RGB field offsets.
- One sub-module, pipe_reg: parameterised-width register with enable and valid, async active-low clear; instantiated per stage.
- Arithmetic stays inline in coord_shader.

Test Plan:
- Reset, then a single beat x=3, y=4, X_OFF=Y_OFF=0, R_SHIFT=0, frame_cnt=0, out_ready=1 -> out_valid exactly 3 cycles later with out_pixel=0x19E619, out_first=0, out_lastx=0.
- Corner beat x=-320, y=240, lastx=1 -> rsq=160000.
  - R_SHIFT=0: pixel 0x00FF00, out_lastx=1.
  - R_SHIFT=4: hue=0x10, pixel 0x10EF10.
- Frame count: beat (3,4,first=1), then beat (3,4,first=0) -> first output 0x19E619 with out_first=1; second output hue=0x1A, pixel 0x1AE51B.
- Backpressure: 10-beat stream with out_ready held low cycles 4-8 -> in_ready low on the same cycles, outputs held stable. All 10 pixels delivered in order with no loss or duplication; frame_cnt is not incremented by a stalled first beat.
- Wrap: feed 256 first=1 beats -> frame_cnt returns to 0; beat 257 (3,4) gives 0x19E619.
- Reset mid-stream with 3 beats in flight -> out_valid=0 immediately (asynchronous); no stale beat emitted after release; in_ready=1.
